// File: rtl/cipher_job_ctrl_if.sv
// rtl/cipher_job_ctrl_if.sv - requester, response, entropy, key-store and cipher-core bus of cipher_job_ctrl
interface cipher_job_ctrl_if #(
  parameter int V = 3
);
  localparam int PW = 16 * 8 * V;
  localparam int LW = 8 * V;
  localparam int HW = V * V * 8;

  logic          req0_valid;
  logic          req1_valid;
  logic          req0_ready;
  logic          req1_ready;
  logic [PW-1:0] req0_pt;
  logic [PW-1:0] req1_pt;

  logic          resp_valid;
  logic          resp_ready;
  logic [127:0]  resp_ct;
  logic          resp_id;
  logic          resp_err;

  logic          seed_req;
  logic          seed_valid;
  logic [LW-1:0] seed_L;
  logic [HW-1:0] seed_L_hat;
  logic [159:0]  seed_rng;

  logic [3:0]    ks_addr;
  logic [PW-1:0] ks_data;

  logic          c_en;
  logic [PW-1:0] c_plaintext;
  logic [LW-1:0] c_L;
  logic [HW-1:0] c_L_hat;
  logic [159:0]  c_RNG_seed;
  logic [PW-1:0] c_round_ks;
  logic [3:0]    c_current_round;
  logic          c_can_supply_last;
  logic          c_encryption_running;
  logic          c_is_busy;
  logic [127:0]  c_ciphertext;

  modport master (
    input  req0_valid, req1_valid, req0_pt, req1_pt,
    output req0_ready, req1_ready,
    output resp_valid, resp_ct, resp_id, resp_err,
    input  resp_ready,
    output seed_req,
    input  seed_valid, seed_L, seed_L_hat, seed_rng,
    output ks_addr,
    input  ks_data,
    output c_en, c_plaintext, c_L, c_L_hat, c_RNG_seed, c_round_ks,
    input  c_current_round, c_can_supply_last, c_encryption_running, c_is_busy, c_ciphertext
  );

  modport slave (
    output req0_valid, req1_valid, req0_pt, req1_pt,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_ct, resp_id, resp_err,
    output resp_ready,
    input  seed_req,
    output seed_valid, seed_L, seed_L_hat, seed_rng,
    input  ks_addr,
    output ks_data,
    input  c_en, c_plaintext, c_L, c_L_hat, c_RNG_seed, c_round_ks,
    output c_current_round, c_can_supply_last, c_encryption_running, c_is_busy, c_ciphertext
  );
endinterface

// File: rtl/cipher_job_ctrl.sv
// rtl/cipher_job_ctrl.sv - round-robin job sequencer for one shared masked AES-IPM core with watchdog
module cipher_job_ctrl #(
  parameter int V       = 3,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  cipher_job_ctrl_if.master bus
);
  localparam int PW = 16 * 8 * V;
  localparam int LW = 8 * V;
  localparam int HW = V * V * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;
  logic [7:0]    wdog;
  logic [PW-1:0] pt_q;
  logic [LW-1:0] l_q;
  logic [HW-1:0] l_hat_q;
  logic [159:0]  rng_q;
  logic [127:0]  resp_ct_q;
  logic          resp_id_q;
  logic          resp_err_q;

  logic grant_any;
  logic grant_idx;
  logic job_done;
  logic wdog_expired;

  // On a tie the requester that was not served last wins.
  assign grant_any    = bus.req0_valid | bus.req1_valid;
  assign grant_idx    = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign job_done     = !bus.c_is_busy && !bus.c_encryption_running;
  assign wdog_expired = (wdog == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.seed_req   = 1'b0;
    bus.c_en       = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          if (grant_idx) begin
            bus.req1_ready = 1'b1;
          end else begin
            bus.req0_ready = 1'b1;
          end
          state_nxt = SEED;
        end
      end
      SEED: begin
        bus.seed_req = 1'b1;
        if (bus.seed_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.c_en = 1'b1;
        if (job_done || wdog_expired) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      wdog       <= 8'd0;
      pt_q       <= '0;
      l_q        <= '0;
      l_hat_q    <= '0;
      rng_q      <= '0;
      resp_ct_q  <= '0;
      resp_id_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            pt_q      <= grant_idx ? bus.req1_pt : bus.req0_pt;
            resp_id_q <= grant_idx;
          end
        end
        SEED: begin
          if (bus.seed_valid) begin
            l_q     <= bus.seed_L;
            l_hat_q <= bus.seed_L_hat;
            rng_q   <= bus.seed_rng;
          end
        end
        RUN: begin
          // Completion takes priority over a watchdog hit in the same cycle.
          if (job_done) begin
            resp_ct_q  <= bus.c_ciphertext;
            resp_err_q <= 1'b0;
          end else if (wdog_expired) begin
            resp_ct_q  <= '0;
            resp_err_q <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            last_grant <= resp_id_q;
            pt_q       <= '0;
            l_q        <= '0;
            l_hat_q    <= '0;
            rng_q      <= '0;
            wdog       <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Key store address only follows the core while it runs.
  assign bus.ks_addr      = (state == RUN) ? (bus.c_can_supply_last ? 4'd10 : bus.c_current_round) : 4'd0;
  assign bus.c_round_ks   = bus.ks_data;
  assign bus.c_plaintext  = pt_q;
  assign bus.c_L          = l_q;
  assign bus.c_L_hat      = l_hat_q;
  assign bus.c_RNG_seed   = rng_q;
  assign bus.resp_ct      = resp_ct_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_err     = resp_err_q;
endmodule

// File: tb/tb_cipher_job_ctrl.sv
// tb/tb_cipher_job_ctrl.sv - scoreboard bench for cipher_job_ctrl with an AES core and key-store model
module tb_cipher_job_ctrl;
  localparam int V       = 3;
  localparam int TIMEOUT = 255;
  localparam int PW      = 16 * 8 * V;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst;

  cipher_job_ctrl_if #(.V(V)) bus ();

  cipher_job_ctrl #(.V(V), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [129:0] sb[$];
  bit   grant_log[$];
  int   run_total = 0;
  int   ks_viol   = 0;
  int   stall_cfg = 0;
  int   seed_cyc  = 0;
  bit   hang      = 1'b0;
  logic [23:0]  lval = 24'hca5301;
  logic [71:0]  cur_lhat = '0;
  logic [159:0] cur_rng  = '0;
  logic [7:0]   sbox [256];
  logic [10:0][127:0] rk_ref;
  logic [10:0][PW-1:0] ks_mem;

  task automatic check(input string name, input bit ok, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [PW-1:0] mask_vec(input logic [127:0] x, input logic [23:0] l);
    logic [PW-1:0] m;
    logic [7:0] s1, s2;
    for (int b = 0; b < 16; b++) begin
      s1 = 8'($urandom);
      s2 = 8'($urandom);
      m[(b*3)*8 +: 8]   = x[127-8*b -: 8] ^ gmul(l[15:8], s1) ^ gmul(l[23:16], s2);
      m[(b*3+1)*8 +: 8] = s1;
      m[(b*3+2)*8 +: 8] = s2;
    end
    return m;
  endfunction

  function automatic logic [127:0] unmask_vec(input logic [PW-1:0] m, input logic [23:0] l);
    logic [127:0] x;
    logic [7:0] acc;
    for (int b = 0; b < 16; b++) begin
      acc = 8'h00;
      for (int i = 0; i < 3; i++) acc = acc ^ gmul(l[8*i +: 8], m[(b*3+i)*8 +: 8]);
      x[127-8*b -: 8] = acc;
    end
    return x;
  endfunction

  function automatic logic [10:0][127:0] expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [10:0][127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]] ^ rc, sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [10:0][127:0] rks);
    logic [127:0] s;
    logic [7:0] a [16];
    logic [7:0] t [16];
    s = pt ^ rks[0];
    for (int r = 1; r < 11; r++) begin
      for (int k = 0; k < 16; k++) a[k] = sbox[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = a[w+4*((c+w)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          a[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          a[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          a[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end
        for (int k = 0; k < 16; k++) t[k] = a[k];
      end
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = t[k];
      s = s ^ rks[r];
    end
    return s;
  endfunction

  // Core model: 11 key-consuming cycles, 17 unmask cycles, then is_busy drops.
  logic [5:0]          mcnt = '0;
  logic [127:0]        mpt  = '0;
  logic [127:0]        mct  = '0;
  logic [10:0][127:0]  rk_seen = '0;

  always @(posedge clk) begin
    if (!bus.c_en) begin
      mcnt <= 6'd0;
    end else begin
      if (mcnt != 6'd63) mcnt <= mcnt + 6'd1;
      if (mcnt == 6'd0) mpt <= unmask_vec(bus.c_plaintext, bus.c_L);
      if (mcnt <= 6'd10) rk_seen[mcnt[3:0]] <= unmask_vec(bus.c_round_ks, bus.c_L);
      if (mcnt == 6'd27) mct <= aes_enc(mpt, rk_seen);
    end
  end

  assign bus.c_is_busy            = !bus.c_en || hang || (mcnt < 6'd28);
  assign bus.c_encryption_running = bus.c_en && (mcnt <= 6'd10);
  assign bus.c_current_round      = (bus.c_en && mcnt <= 6'd9) ? mcnt[3:0] :
                                    (bus.c_en && mcnt == 6'd10) ? 4'd9 : 4'd0;
  assign bus.c_can_supply_last    = bus.c_en && (mcnt == 6'd10);
  assign bus.c_ciphertext         = (mcnt >= 6'd28) ? mct : 128'h0;
  assign bus.ks_data              = (bus.ks_addr <= 4'd10) ? ks_mem[bus.ks_addr] : '0;

  // Entropy source: answers after stall_cfg cycles of seed_req.
  initial begin
    bus.seed_valid = 1'b0;
    bus.seed_L     = '0;
    bus.seed_L_hat = '0;
    bus.seed_rng   = '0;
    forever begin
      @(negedge clk);
      if (bus.seed_req) begin
        if (seed_cyc >= stall_cfg) begin
          cur_lhat       = {8'($urandom), $urandom, $urandom};
          cur_rng        = {$urandom, $urandom, $urandom, $urandom, $urandom};
          bus.seed_valid = 1'b1;
          bus.seed_L     = lval;
          bus.seed_L_hat = cur_lhat;
          bus.seed_rng   = cur_rng;
        end else begin
          bus.seed_valid = 1'b0;
        end
        seed_cyc++;
      end else begin
        bus.seed_valid = 1'b0;
        seed_cyc       = 0;
      end
    end
  end

  // Monitor and scoreboard checker.
  initial begin
    logic [129:0] e;
    forever begin
      @(negedge clk);
      if (bus.req0_ready) grant_log.push_back(1'b0);
      if (bus.req1_ready) grant_log.push_back(1'b1);
      if (bus.c_en) run_total++;
      if (!bus.c_en && bus.ks_addr != 4'd0) ks_viol++;
      if (bus.c_en && mcnt == 6'd0) begin
        check("seed_L_latch", bus.c_L == lval, 160'(bus.c_L), 160'(lval));
        check("seed_L_hat_latch", bus.c_L_hat == cur_lhat, 160'(bus.c_L_hat), 160'(cur_lhat));
        check("seed_rng_latch", bus.c_RNG_seed == cur_rng, bus.c_RNG_seed, cur_rng);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1'b0, 160'({bus.resp_err, bus.resp_id, bus.resp_ct}), 160'h0);
        end else begin
          e = sb.pop_front();
          check("resp", {bus.resp_err, bus.resp_id, bus.resp_ct} == e,
                160'({bus.resp_err, bus.resp_id, bus.resp_ct}), 160'(e));
        end
      end
    end
  end

  task automatic do_req(input bit n, input logic [127:0] pt);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (n) begin bus.req1_valid = 1'b1; bus.req1_pt = mask_vec(pt, lval); end
    else   begin bus.req0_valid = 1'b1; bus.req0_pt = mask_vec(pt, lval); end
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      got = n ? bus.req1_ready : bus.req0_ready;
    end
    check(n ? "grant_req1" : "grant_req0", got, 160'(got), 160'd1);
    @(posedge clk); #1;
    if (n) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = (sb.size() == 0) && !bus.resp_valid && !bus.c_en && !bus.seed_req;
    end
    check("idle_reached", ok, 160'(ok), 160'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [127:0] ct_snap;
    int g0, t0, viol;
    bit found;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, q;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      q = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = q;
    end
    rk_ref = expand_key(FIPS_KEY);
    for (int r = 0; r < 11; r++) ks_mem[r] = mask_vec(rk_ref[r], lval);

    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_pt = '0; bus.req1_pt = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_state",
          {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_err, bus.seed_req,
           bus.c_en, bus.ks_addr, |bus.resp_ct, |bus.c_plaintext, |bus.c_L, |bus.c_L_hat, |bus.c_RNG_seed} == '0,
          160'({bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_err, bus.seed_req,
                bus.c_en, bus.ks_addr, |bus.resp_ct, |bus.c_plaintext, |bus.c_L, |bus.c_L_hat, |bus.c_RNG_seed}),
          160'h0);

    // Single FIPS-197 job on req0
    g0 = grant_log.size();
    t0 = run_total;
    sb.push_back({1'b0, 1'b0, FIPS_CT});
    do_req(1'b0, FIPS_PT);
    wait_idle();
    check("single_grant_count", grant_log.size() - g0 == 1, 160'(grant_log.size() - g0), 160'd1);
    check("single_grant_id", grant_log[g0] == 1'b0, 160'(grant_log[g0]), 160'd0);
    check("run_latency", run_total - t0 == 29, 160'(run_total - t0), 160'd29);
    @(negedge clk);
    check("mask_hygiene", {|bus.c_plaintext, |bus.c_L, |bus.c_L_hat, |bus.c_RNG_seed} == 4'h0,
          160'({|bus.c_plaintext, |bus.c_L, |bus.c_L_hat, |bus.c_RNG_seed}), 160'h0);

    // Tie arbitration from reset: expected order 0,1,0
    apply_reset();
    g0 = grant_log.size();
    sb.push_back({1'b0, 1'b0, aes_enc(128'h0123456789abcdeffedcba9876543210, rk_ref)});
    sb.push_back({1'b0, 1'b1, aes_enc(128'hdeadbeef00000000cafef00d12345678, rk_ref)});
    sb.push_back({1'b0, 1'b0, aes_enc(128'hffffffffffffffffffffffffffffffff, rk_ref)});
    fork
      begin
        do_req(1'b0, 128'h0123456789abcdeffedcba9876543210);
        do_req(1'b0, 128'hffffffffffffffffffffffffffffffff);
      end
      do_req(1'b1, 128'hdeadbeef00000000cafef00d12345678);
    join
    wait_idle();
    check("tie_grant_count", grant_log.size() - g0 == 3, 160'(grant_log.size() - g0), 160'd3);
    if (grant_log.size() - g0 == 3)
      check("tie_grant_order", {grant_log[g0], grant_log[g0+1], grant_log[g0+2]} == 3'b010,
            160'({grant_log[g0], grant_log[g0+1], grant_log[g0+2]}), 160'b010);

    // Seed stall of 20 cycles on req1
    stall_cfg = 20;
    viol = 0;
    sb.push_back({1'b0, 1'b1, aes_enc(128'h00000000000000000000000000000001, rk_ref)});
    do_req(1'b1, 128'h00000000000000000000000000000001);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.seed_req || bus.c_en) viol++;
    end
    check("seed_stall_hold", viol == 0, 160'(viol), 160'd0);
    wait_idle();
    stall_cfg = 0;

    // Watchdog: core never finishes
    hang = 1'b1;
    t0 = run_total;
    sb.push_back({1'b1, 1'b0, 128'h0});
    do_req(1'b0, 128'h13579bdf2468ace013579bdf2468ace0);
    wait_idle();
    check("wdog_run_cycles", run_total - t0 == TIMEOUT + 1, 160'(run_total - t0), 160'(TIMEOUT + 1));
    hang = 1'b0;

    // Backpressure: response held 10 cycles, req1 waits behind it
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    sb.push_back({1'b0, 1'b0, aes_enc(128'h8899aabbccddeeff0011223344556677, rk_ref)});
    sb.push_back({1'b0, 1'b1, aes_enc(128'h0f0e0d0c0b0a09080706050403020100, rk_ref)});
    do_req(1'b0, 128'h8899aabbccddeeff0011223344556677);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      found = bus.resp_valid;
    end
    check("bp_resp_seen", found, 160'(found), 160'd1);
    ct_snap = bus.resp_ct;
    fork
      do_req(1'b1, 128'h0f0e0d0c0b0a09080706050403020100);
    join_none
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_ct != ct_snap || bus.resp_id != 1'b0 || bus.req1_ready) viol++;
    end
    check("bp_stable", viol == 0, 160'(viol), 160'd0);
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    wait_idle();

    // Reset during round 5: job lost, fresh job afterwards
    do_req(1'b0, 128'h55555555555555555555555555555555);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      found = bus.c_en && (mcnt == 6'd5);
    end
    check("round5_reached", found, 160'(found), 160'd1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.c_en, bus.resp_valid, bus.seed_req, bus.ks_addr, |bus.c_plaintext, |bus.c_L} == '0,
          160'({bus.c_en, bus.resp_valid, bus.seed_req, bus.ks_addr, |bus.c_plaintext, |bus.c_L}), 160'h0);
    @(posedge clk); #1 rst = 1'b1;
    sb.push_back({1'b0, 1'b1, aes_enc(128'haaaaaaaa55555555aaaaaaaa55555555, rk_ref)});
    do_req(1'b1, 128'haaaaaaaa55555555aaaaaaaa55555555);
    wait_idle();

    check("scoreboard_empty", sb.size() == 0, 160'(sb.size()), 160'd0);
    check("ks_addr_idle_zero", ks_viol == 0, 160'(ks_viol), 160'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cipher_job_ctrl.md
# cipher_job_ctrl

Job controller that sequences one masked AES-IPM cipher core and shares it between two requesters. It arbitrates requests round-robin, fetches fresh mask material (L, L_hat, RNG seed) per job from an entropy source, and drives the core's enable and inputs. It steers round keys from a key store and returns the unmasked ciphertext through a valid/ready response port. A watchdog aborts jobs that never complete.

## Interface
- v, 3, masking order; shares per byte.
- TIMEOUT, 255, maximum RUN cycles before abort; fits in 8 bits.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester job request.
- req0_ready / req1_ready  out  1  one-cycle accept pulse.
- req0_pt / req1_pt  in  16*8*v  masked plaintext.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_ct  out  128  unmasked ciphertext; 0 on error.
- resp_id  out  1  requester index of the job.
- resp_err  out  1  watchdog abort.
- seed_req  out  1  request fresh mask material.
- seed_valid  in  1  mask material valid.
- seed_L  in  8*v; seed_L_hat  in  v*v*8; seed_rng  in  160.
- ks_addr  out  4  round-key index to key store.
- ks_data  in  16*8*v  masked round key for ks_addr, combinational read.
- c_en  out  1  core enable; low holds the core in reset.
- c_plaintext  out  16*8*v; c_L  out  8*v; c_L_hat  out  v*v*8; c_RNG_seed  out  160; c_round_ks  out  16*8*v.
- c_current_round  in  4; c_can_supply_last  in  1; c_encryption_running  in  1; c_is_busy  in  1; c_ciphertext  in  128.

## Operation
- States: IDLE, SEED, RUN, RESP.
- IDLE:
  - If any reqN_valid, grant one requester: pulse its reqN_ready for 1 cycle.
  - Latch reqN_pt into c_plaintext and N into resp_id, then go to SEED.
  - Arbitration: if only one request is valid, grant it. If both are valid, grant the requester not granted last. last_grant resets to 1, so req0 wins the first tie.
- SEED:
  - seed_req = 1.
  - On seed_valid, latch seed_L, seed_L_hat and seed_rng into c_L, c_L_hat and c_RNG_seed, then go to RUN.
  - No timeout in SEED.
- RUN:
  - c_en = 1. Watchdog wdog increments each cycle.
  - Job completes when c_is_busy==0 and c_encryption_running==0. The core holds is_busy at 1 while disabled and clears it only after unmasking all 16 bytes.
  - On completion: resp_ct <= c_ciphertext, resp_err <= 0, go to RESP.
  - If wdog==TIMEOUT without completion: resp_ct <= 0, resp_err <= 1, go to RESP.
  - c_en drops on leaving RUN, which resets the core.
- RESP:
  - resp_valid = 1 until resp_ready is sampled high.
  - Then: update last_grant to resp_id; zero c_plaintext, c_L, c_L_hat and c_RNG_seed (mask hygiene); clear wdog; go to IDLE.
- Key steering (combinational):
  - ks_addr = c_can_supply_last ? 4'd10 : c_current_round.
  - c_round_ks = ks_data.
  - ks_addr is forced to 0 outside RUN.
- Requests arriving outside IDLE are not accepted; reqN_ready stays 0 and requesters hold valid.

## Timing
- Reset (async, rst low): state=IDLE, all outputs 0, all data registers 0, wdog=0, last_grant=1.
- Reset mid-RUN: c_en falls immediately, the job is lost, and no response is issued.
- The request grant pulse occurs in the cycle IDLE is left. SEED is entered on the next edge.
- seed_valid sampled in the first SEED cycle gives RUN on the following edge. Minimum SEED dwell is 1 cycle.
- RUN latency equals the core latency (rounds plus 17 unmask cycles) plus 1 cycle of detection.
- resp_valid rises 1 cycle after the completion condition.
- resp_valid and resp_ready high on the same edge: accept, and IDLE on the next cycle.
- Minimum back-to-back job spacing is 1 IDLE cycle; a new grant can occur in the first IDLE cycle.
- A request valid together with completion in the same cycle is granted only after RESP is accepted.

## Test plan
- Single job: req0 carries the FIPS-197 plaintext 00112233445566778899aabbccddeeff, masked by the bench model, with key 000102…0f. Expected: resp_ct=69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=0, resp_err=0, req0_ready pulsed once.
- Tie arbitration: req0 and req1 valid together for three jobs. Expected grant order 0,1,0 and correct resp_id on each response.
- Seed stall: hold seed_valid low for 20 cycles. Expected: seed_req stays high, c_en stays 0, and the job completes correctly afterwards.
- Watchdog: the core model never clears is_busy. Expected: after TIMEOUT cycles of RUN, resp_err=1, resp_ct=0, c_en falls, and the controller returns to IDLE.
- Backpressure: resp_ready held low for 10 cycles. Expected: resp_valid, resp_ct and resp_id stay stable and req1 is not granted until the response is accepted.
- Reset mid-RUN: assert rst during round 5. Expected: outputs go to 0 asynchronously, no response is issued, and a fresh job afterwards completes correctly.
